retire_trace_buffer: RTL and testbench

//  Synthesizable successor to the bench-only retirement logger. It samples the CPU

---
 rtl/trace_pkg.sv | 29 ++
 rtl/retire_trace_buffer_if.sv | 32 +++
 rtl/trace_fifo.sv | 62 ++++++
 rtl/retire_trace_buffer.sv | 124 ++++++++++++
 tb/tb_retire_trace_buffer.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared constants for the retire trace buffer: record kinds, record width helper
// and field offsets of rec_data for the default parameter set.
package trace_pkg;

  localparam logic [2:0] KIND_NOP   = 3'd0;
  localparam logic [2:0] KIND_REG   = 3'd1;
  localparam logic [2:0] KIND_LOAD  = 3'd2;
  localparam logic [2:0] KIND_STORE = 3'd3;
  localparam logic [2:0] KIND_HALT  = 3'd4;

  function automatic int rec_width(input int cnt_w, input int data_w, input int reg_aw);
    return cnt_w + 3 * data_w + 3 + reg_aw;
  endfunction

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 4;
  localparam int CNT_W_DEF  = 32;

  localparam int REC_W = rec_width(CNT_W_DEF, DATA_W_DEF, REG_AW_DEF);

  // rec_data = {inum, pc, kind, reg, value, addr}, addr in the LSBs.
  localparam int OFS_ADDR  = 0;
  localparam int OFS_VALUE = OFS_ADDR + DATA_W_DEF;
  localparam int OFS_REG   = OFS_VALUE + DATA_W_DEF;
  localparam int OFS_KIND  = OFS_REG + REG_AW_DEF;
  localparam int OFS_PC    = OFS_KIND + 3;
  localparam int OFS_INUM  = OFS_PC + DATA_W_DEF;

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Retire event bus from the CPU plus the valid/ready record stream to the drain host.
interface retire_trace_buffer_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int REC_W  = 87
);
  logic              ret_valid;
  logic [DATA_W-1:0] ret_pc;
  logic              ret_regw;
  logic [REG_AW-1:0] ret_wreg;
  logic [DATA_W-1:0] ret_wdata;
  logic              ret_memr;
  logic              ret_memw;
  logic [DATA_W-1:0] ret_maddr;
  logic [DATA_W-1:0] ret_mdata;
  logic              ret_hlt;
  logic              rec_valid;
  logic              rec_ready;
  logic [REC_W-1:0]  rec_data;

  modport master (
    output ret_valid, ret_pc, ret_regw, ret_wreg, ret_wdata, ret_memr, ret_memw,
           ret_maddr, ret_mdata, ret_hlt, rec_ready,
    input  rec_valid, rec_data
  );

  modport slave (
    input  ret_valid, ret_pc, ret_regw, ret_wreg, ret_wdata, ret_memr, ret_memw,
           ret_maddr, ret_mdata, ret_hlt, rec_ready,
    output rec_valid, rec_data
  );
endinterface

// File: rtl/trace_fifo.sv
// Circular record buffer with first-word-fall-through head, drop-or-overwrite on full,
// and a one-cycle drop pulse for every record lost.
module trace_fifo #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             empty, full, pop, wr_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = pop_i && !empty;

  // A pop in the same cycle frees the slot, so a full buffer still takes the push.
  assign drop_o = push_i && full && !pop;
  assign wr_en  = push_i && (!full || pop || OVERWRITE);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en)
      wptr_d = wptr_q + (AW+1)'(1);
    if (pop || (drop_o && OVERWRITE))
      rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/retire_trace_buffer.sv
// Classifies CPU retire events into trace records, buffers them for a drain host,
// and keeps cycle/instruction/drop counters with sticky halt and watchdog timeout.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 4,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 100000,
  parameter bit OVERWRITE   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  retire_trace_buffer_if.slave bus,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     inst_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 halted,
  output logic                 timeout
);
  localparam int REC_WIDTH = rec_width(CNT_W, DATA_W, REG_AW);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);

  logic [CNT_W-1:0]     cycle_q, cycle_d, inst_q, inst_d, drop_q, drop_d;
  logic                 halted_q, halted_d, timeout_q, timeout_d;
  logic                 capture, accept, fifo_drop;
  logic [2:0]           kind;
  logic [REG_AW-1:0]    rec_reg;
  logic [DATA_W-1:0]    rec_value, rec_addr;
  logic [REC_WIDTH-1:0] rec_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign capture = en && !halted_q && !timeout_q;
  assign accept  = capture && bus.ret_valid;

  // Halt outranks everything; a load is a register write that also reads memory.
  always_comb begin
    kind      = KIND_NOP;
    rec_reg   = '0;
    rec_value = '0;
    rec_addr  = '0;
    if (bus.ret_hlt) begin
      kind = KIND_HALT;
    end else if (bus.ret_regw && bus.ret_memr) begin
      kind      = KIND_LOAD;
      rec_reg   = bus.ret_wreg;
      rec_value = bus.ret_wdata;
      rec_addr  = bus.ret_maddr;
    end else if (bus.ret_regw) begin
      kind      = KIND_REG;
      rec_reg   = bus.ret_wreg;
      rec_value = bus.ret_wdata;
    end else if (bus.ret_memw) begin
      kind      = KIND_STORE;
      rec_value = bus.ret_mdata;
      rec_addr  = bus.ret_maddr;
    end
  end

  assign rec_word = {inst_q, bus.ret_pc, kind, rec_reg, rec_value, rec_addr};

  trace_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (REC_WIDTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .data_i  (rec_word),
    .pop_i   (bus.rec_ready),
    .valid_o (bus.rec_valid),
    .data_o  (bus.rec_data),
    .drop_o  (fifo_drop)
  );

  always_comb begin
    cycle_d   = cycle_q;
    inst_d    = inst_q;
    drop_d    = drop_q;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    if (capture) begin
      cycle_d = sat_inc(cycle_q);
      if (cycle_q == LIMIT_M1)
        timeout_d = 1'b1;
    end
    if (accept) begin
      inst_d = sat_inc(inst_q);
      if (bus.ret_hlt)
        halted_d = 1'b1;
    end
    if (fifo_drop)
      drop_d = sat_inc(drop_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      inst_q    <= '0;
      drop_q    <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      inst_q    <= inst_d;
      drop_q    <= drop_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
    end
  end

  assign cycle_cnt = cycle_q;
  assign inst_cnt  = inst_q;
  assign drop_cnt  = drop_q;
  assign halted    = halted_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Drives three buffer instances (drop mode, overwrite mode, short watchdog) from one
// retire stream and compares every cycle against a queue-based reference model.
module tb_retire_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam longint unsigned CMAX = 64'h0000_0000_FFFF_FFFF;
  typedef logic [REC_W-1:0] rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        r_valid, r_regw, r_memr, r_memw, r_hlt;
  logic [15:0] r_pc, r_wdata, r_maddr, r_mdata;
  logic [3:0]  r_wreg;
  logic [2:0]  en, ready;

  logic        o_valid [3];
  rec_t        o_data  [3];
  logic [31:0] o_cyc   [3];
  logic [31:0] o_inst  [3];
  logic [31:0] o_drop  [3];
  logic        o_halt  [3];
  logic        o_to    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    retire_trace_buffer_if #(.DATA_W(16), .REG_AW(4), .REC_W(REC_W)) bus ();
    assign bus.ret_valid = r_valid;
    assign bus.ret_pc    = r_pc;
    assign bus.ret_regw  = r_regw;
    assign bus.ret_wreg  = r_wreg;
    assign bus.ret_wdata = r_wdata;
    assign bus.ret_memr  = r_memr;
    assign bus.ret_memw  = r_memw;
    assign bus.ret_maddr = r_maddr;
    assign bus.ret_mdata = r_mdata;
    assign bus.ret_hlt   = r_hlt;
    assign bus.rec_ready = ready[g];
    assign o_valid[g]    = bus.rec_valid;
    assign o_data[g]     = bus.rec_data;

    retire_trace_buffer #(
      .DATA_W(16), .REG_AW(4), .DEPTH(DEPTH), .CNT_W(32),
      .CYCLE_LIMIT((g == 2) ? 50 : 100000), .OVERWRITE(g == 1)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en[g]),
      .bus       (bus),
      .cycle_cnt (o_cyc[g]),
      .inst_cnt  (o_inst[g]),
      .drop_cnt  (o_drop[g]),
      .halted    (o_halt[g]),
      .timeout   (o_to[g])
    );
  end

  // ---------------- reference model ----------------
  rec_t            mq [3][$];
  longint unsigned m_inst [3], m_cyc [3], m_drop [3];
  bit              m_halt [3], m_to [3];
  int              n_err = 0;
  int              n_checks = 0;
  string           phase = "init";

  function automatic bit ow_of(input int i);
    return i == 1;
  endfunction

  function automatic longint unsigned lim_of(input int i);
    return (i == 2) ? 50 : 100000;
  endfunction

  function automatic longint unsigned sat(input longint unsigned v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic rec_t mk_rec(input longint unsigned inum);
    logic [31:0] n;
    logic [2:0]  k;
    logic [3:0]  rg;
    logic [15:0] val, adr;
    n = 32'(inum); rg = '0; val = '0; adr = '0;
    if (r_hlt)                 k = 3'd4;
    else if (r_regw && r_memr) begin k = 3'd2; rg = r_wreg; val = r_wdata; adr = r_maddr; end
    else if (r_regw)           begin k = 3'd1; rg = r_wreg; val = r_wdata; end
    else if (r_memw)           begin k = 3'd3; val = r_mdata; adr = r_maddr; end
    else                       k = 3'd0;
    return {n, r_pc, k, rg, val, adr};
  endfunction

  task automatic model_step(input int i);
    bit   cap, acc, pop, full;
    rec_t r;
    cap  = en[i] && !m_halt[i] && !m_to[i];
    acc  = cap && r_valid;
    pop  = (mq[i].size() != 0) && ready[i];
    full = (mq[i].size() == DEPTH);
    r    = mk_rec(m_inst[i]);
    if (pop) void'(mq[i].pop_front());
    if (acc) begin
      if (full && !pop) begin
        m_drop[i] = sat(m_drop[i]);
        if (ow_of(i)) begin
          void'(mq[i].pop_front());
          mq[i].push_back(r);
        end
      end else begin
        mq[i].push_back(r);
      end
      m_inst[i] = sat(m_inst[i]);
      if (r_hlt) m_halt[i] = 1'b1;
    end
    if (cap) begin
      if (m_cyc[i] == lim_of(i) - 1) m_to[i] = 1'b1;
      m_cyc[i] = sat(m_cyc[i]);
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s[%0d].rec_valid", phase, i), o_valid[i], mq[i].size() != 0);
      if (mq[i].size() != 0)
        check($sformatf("%s[%0d].rec_data", phase, i), o_data[i], mq[i][0]);
      check($sformatf("%s[%0d].cycle_cnt", phase, i), o_cyc[i], m_cyc[i]);
      check($sformatf("%s[%0d].inst_cnt", phase, i), o_inst[i], m_inst[i]);
      check($sformatf("%s[%0d].drop_cnt", phase, i), o_drop[i], m_drop[i]);
      check($sformatf("%s[%0d].halted", phase, i), o_halt[i], m_halt[i]);
      check($sformatf("%s[%0d].timeout", phase, i), o_to[i], m_to[i]);
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    r_valid = 0; r_regw = 0; r_memr = 0; r_memw = 0; r_hlt = 0;
    r_pc = '0; r_wdata = '0; r_maddr = '0; r_mdata = '0; r_wreg = '0;
  endtask

  // Asserts reset away from the clock edge and checks outputs clear before any edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    en = '0; ready = '0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      m_inst[i] = 0; m_cyc[i] = 0; m_drop[i] = 0; m_halt[i] = 0; m_to[i] = 0;
    end
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s[%0d].rec_valid", tag, i), o_valid[i], 1'b0);
      check($sformatf("%s[%0d].rec_data", tag, i), o_data[i], '0);
      check($sformatf("%s[%0d].cycle_cnt", tag, i), o_cyc[i], '0);
      check($sformatf("%s[%0d].inst_cnt", tag, i), o_inst[i], '0);
      check($sformatf("%s[%0d].drop_cnt", tag, i), o_drop[i], '0);
      check($sformatf("%s[%0d].halted", tag, i), o_halt[i], 1'b0);
      check($sformatf("%s[%0d].timeout", tag, i), o_to[i], 1'b0);
    end
    #2;
    rst = 1'b0;
  endtask

  task automatic set_event(input logic [15:0] pc, input logic regw, input logic [3:0] wreg,
                           input logic [15:0] wdata, input logic memr, input logic memw,
                           input logic [15:0] maddr, input logic [15:0] mdata,
                           input logic hlt);
    r_valid = 1; r_pc = pc; r_regw = regw; r_wreg = wreg; r_wdata = wdata;
    r_memr = memr; r_memw = memw; r_maddr = maddr; r_mdata = mdata; r_hlt = hlt;
  endtask

  task automatic rand_event(input bit allow_hlt);
    r_valid = 1'($urandom_range(0, 3) != 0);
    r_pc    = 16'($urandom); r_wdata = 16'($urandom);
    r_maddr = 16'($urandom); r_mdata = 16'($urandom);
    r_wreg  = 4'($urandom);
    r_regw  = 1'($urandom); r_memr = 1'($urandom); r_memw = 1'($urandom);
    r_hlt   = allow_hlt && ($urandom_range(0, 127) == 0);
  endtask

  function automatic logic [31:0] f_inum(input rec_t d);
    return d[OFS_INUM +: 32];
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] pc;
    logic        regw;
    logic [3:0]  wreg;
    logic [15:0] wdata;
    logic        memr;
    logic        memw;
    logic [15:0] maddr;
    logic [15:0] mdata;
    logic [2:0]  e_kind;
    logic [3:0]  e_reg;
    logic [15:0] e_value;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vt [4];

  initial begin
    int cnt [2], first [2], last [2];
    rec_t d;

    vt[0] = '{16'h0000, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000,
              3'd1, 4'd3, 16'h1234, 16'h0000};
    vt[1] = '{16'h0002, 1'b1, 4'd5, 16'hBEEF, 1'b1, 1'b0, 16'h0040, 16'h0000,
              3'd2, 4'd5, 16'hBEEF, 16'h0040};
    vt[2] = '{16'h0004, 1'b0, 4'd7, 16'h9999, 1'b0, 1'b1, 16'h0042, 16'h00AA,
              3'd3, 4'd0, 16'h00AA, 16'h0042};
    vt[3] = '{16'h0006, 1'b0, 4'd9, 16'h5555, 1'b0, 1'b0, 16'h0077, 16'h6666,
              3'd0, 4'd0, 16'h0000, 16'h0000};

    do_reset("reset");

    // Test 1: four kinds, each record visible the cycle after acceptance.
    phase = "t1";
    en = 3'b001; ready = 3'b001;
    for (int k = 0; k < 4; k++) begin
      set_event(vt[k].pc, vt[k].regw, vt[k].wreg, vt[k].wdata, vt[k].memr,
                vt[k].memw, vt[k].maddr, vt[k].mdata, 1'b0);
      tick();
      d = o_data[0];
      check($sformatf("t1.valid%0d", k), o_valid[0], 1'b1);
      check($sformatf("t1.inum%0d", k), d[OFS_INUM +: 32], k);
      check($sformatf("t1.pc%0d", k), d[OFS_PC +: 16], vt[k].pc);
      check($sformatf("t1.kind%0d", k), d[OFS_KIND +: 3], vt[k].e_kind);
      check($sformatf("t1.reg%0d", k), d[OFS_REG +: 4], vt[k].e_reg);
      check($sformatf("t1.value%0d", k), d[OFS_VALUE +: 16], vt[k].e_value);
      check($sformatf("t1.addr%0d", k), d[OFS_ADDR +: 16], vt[k].e_addr);
    end
    idle_inputs();
    tick();
    check("t1.inst_cnt", o_inst[0], 32'd4);
    check("t1.drained", o_valid[0], 1'b0);

    // Tests 2-4: 20 events into a stalled buffer, then push+pop while full.
    do_reset("reset2");
    phase = "t2";
    en = 3'b011; ready = 3'b000;
    for (int k = 0; k < 20; k++) begin
      set_event(16'(k), 1'b1, 4'(k), 16'(16'h0100 + k), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t2.drop[%0d]", i), o_drop[i], 32'd4);
      check($sformatf("t2.inst[%0d]", i), o_inst[i], 32'd20);
      check($sformatf("t2.valid[%0d]", i), o_valid[i], 1'b1);
    end
    check("t2.head_inum_drop", f_inum(o_data[0]), 32'd0);
    check("t3.head_inum_ovw", f_inum(o_data[1]), 32'd4);

    phase = "t4";
    set_event(16'd20, 1'b1, 4'd4, 16'h0114, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    ready = 3'b011;
    tick();
    check("t4.drop_drop", o_drop[0], 32'd4);
    check("t4.drop_ovw", o_drop[1], 32'd4);
    idle_inputs();
    cnt = '{0, 0}; first = '{-1, -1}; last = '{-1, -1};
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (o_valid[i]) begin
          if (cnt[i] == 0) first[i] = int'(f_inum(o_data[i]));
          last[i] = int'(f_inum(o_data[i]));
          cnt[i]++;
        end
      end
      tick();
    end
    check("t4.occupancy_drop", cnt[0], 16);
    check("t4.occupancy_ovw", cnt[1], 16);
    check("t4.first_drop", first[0], 1);
    check("t4.first_ovw", first[1], 5);
    check("t4.last_drop", last[0], 20);
    check("t4.last_ovw", last[1], 20);

    // Test 5: halt freezes capture and counters; buffer still drains.
    do_reset("reset5");
    phase = "t5";
    en = 3'b001; ready = 3'b000;
    set_event(16'h0010, 1'b1, 4'd1, 16'h0011, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0); tick();
    set_event(16'h0012, 1'b1, 4'd2, 16'h0022, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0); tick();
    set_event(16'h001E, 1'b1, 4'd3, 16'h0033, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1); tick();
    check("t5.halted", o_halt[0], 1'b1);
    for (int k = 0; k < 3; k++) begin
      set_event(16'(16'h0020 + 2 * k), 1'b1, 4'd6, 16'hABCD, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    check("t5.inst_frozen", o_inst[0], 32'd3);
    check("t5.cycle_frozen", o_cyc[0], 32'd3);
    idle_inputs();
    ready = 3'b001;
    tick();
    tick();
    d = o_data[0];
    check("t5.last_valid", o_valid[0], 1'b1);
    check("t5.last_kind", d[OFS_KIND +: 3], 3'd4);
    check("t5.last_pc", d[OFS_PC +: 16], 16'h001E);
    check("t5.last_value", d[OFS_VALUE +: 16], 16'h0000);
    tick();
    check("t5.empty", o_valid[0], 1'b0);

    // Randomized traffic on the drop and overwrite instances.
    do_reset("reset_rand");
    phase = "rand";
    for (int c = 0; c < 600; c++) begin
      rand_event(1'b1);
      en    = {1'b0, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) != 0)};
      ready = {1'b0, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)};
      tick();
    end

    // Test 6: watchdog after 50 counted cycles, then asynchronous reset mid-stream.
    do_reset("reset6");
    phase = "t6";
    en = 3'b100; ready = 3'b100;
    for (int c = 0; c < 60; c++) begin
      rand_event(1'b0);
      r_valid = 1'b1;
      if (c >= 45) ready = 3'b000;
      tick();
      if (c == 48) begin
        check("t6.no_timeout_49", o_to[2], 1'b0);
        check("t6.cycle_49", o_cyc[2], 32'd49);
      end
      if (c == 49) begin
        check("t6.timeout_50", o_to[2], 1'b1);
        check("t6.cycle_50", o_cyc[2], 32'd50);
      end
    end
    check("t6.cycle_held", o_cyc[2], 32'd50);
    check("t6.pending", o_valid[2], 1'b1);
    #3;
    do_reset("t6.midrst");
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
